// File: rtl/trace_monitor.sv
// Retirement-trace and statistics monitor with a circular capture buffer.
// Optional TRACE_TIMESTAMP_EN appends a capture-cycle stamp to each entry.
module trace_monitor #(
  parameter int DATA_W    = 16,
  parameter int REG_IDX_W = 4,
  parameter int DEPTH     = 64,
  parameter int CNT_W     = 32,
  parameter int WATCHDOG  = 100000,
  parameter int WRAP      = 1,
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W     = CNT_W,
`else
  localparam int TS_W     = 0,
`endif
  localparam int ENTRY_W  = 3 + REG_IDX_W + 3 * DATA_W + TS_W,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 halt_in,
  input  logic                 reg_we,
  input  logic [REG_IDX_W-1:0] reg_idx,
  input  logic [DATA_W-1:0]    reg_data,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [DATA_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 rd_en,
  output logic                 rd_valid,
  output logic [ENTRY_W-1:0]   rd_data,
  output logic [1:0]           state,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     inst_count,
  output logic [PTR_W:0]       entry_count,
  output logic                 overflow,
  output logic                 proto_err
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    HALTED  = 2'b01,
    TIMEOUT = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [ENTRY_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0] entry;
  logic [DATA_W-1:0]  mem_data;
  logic [CNT_W-1:0]   cyc_next;
  logic               run, wd_hit, full;
  logic               event_v, keep, pop;

  assign run      = state_q == RUN;
  assign state    = state_q;
  assign done     = !run;
  assign cyc_next = (&cycle_count) ? cycle_count
                  : cycle_count + CNT_W'(1);
  assign wd_hit   = (WATCHDOG != 0)
                 && (cyc_next == CNT_W'(WATCHDOG));
  assign full     = entry_count == (PTR_W+1)'(DEPTH);
  assign event_v  = run & (reg_we | mem_rd | mem_wr);
  assign keep     = !full || (WRAP != 0);
  assign pop      = !run && rd_en && (entry_count != '0);

  // A simultaneous read+write is logged as the write.
  assign mem_data = mem_wr ? mem_wdata
                  : (mem_rd ? mem_rdata : {DATA_W{1'b0}});

  assign entry = {
    reg_we,
    mem_rd & ~mem_wr,
    mem_wr,
    reg_we ? reg_idx : {REG_IDX_W{1'b0}},
    reg_we ? reg_data : {DATA_W{1'b0}},
    (mem_rd | mem_wr) ? mem_addr : {DATA_W{1'b0}},
    mem_data
`ifdef TRACE_TIMESTAMP_EN
    , cyc_next
`endif
  };

  always_comb begin
    state_d = state_q;
    if (state_q == RUN) begin
      if (halt_in)     state_d = HALTED;
      else if (wd_hit) state_d = TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (event_v && keep) store[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cycle_count <= '0;
      inst_count  <= '0;
      entry_count <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      proto_err   <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      state_q  <= state_d;
      rd_valid <= 1'b0;
      if (run) begin
        cycle_count <= cyc_next;
        if ((halt_in | reg_we | mem_wr) && !(&inst_count))
          inst_count <= inst_count + CNT_W'(1);
        if (mem_rd & mem_wr) proto_err <= 1'b1;
      end
      if (event_v) begin
        if (keep) wr_ptr <= wr_ptr + PTR_W'(1);
        if (full) begin
          overflow <= 1'b1;
          // Overwriting the oldest entry drags the read side along.
          if (WRAP != 0) rd_ptr <= rd_ptr + PTR_W'(1);
        end else begin
          entry_count <= entry_count + (PTR_W+1)'(1);
        end
      end
      if (pop) begin
        rd_data     <= store[rd_ptr];
        rd_valid    <= 1'b1;
        rd_ptr      <= rd_ptr + PTR_W'(1);
        entry_count <= entry_count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_trace_monitor.sv
// Bench for trace_monitor: three configurations driven in parallel,
// checked against a queue-based model plus directed vectors.
module tb_trace_monitor;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TSW = 32;
`else
  localparam int TSW = 0;
`endif
  localparam int EW = 3 + 4 + 48 + TSW;
  localparam int P_DEPTH [3] = '{64, 4, 4};
  localparam int P_WRAP  [3] = '{1, 1, 0};
  localparam int P_WD    [3] = '{100000, 20, 0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt_in, reg_we, mem_rd, mem_wr, rd_en;
  logic [3:0]  reg_idx;
  logic [15:0] reg_data, mem_addr, mem_wdata, mem_rdata;

  logic [1:0]    st  [3];
  logic          dn  [3];
  logic [31:0]   cc  [3];
  logic [31:0]   ic  [3];
  logic          ov  [3];
  logic          pe  [3];
  logic          rv  [3];
  logic [EW-1:0] rdd [3];
  logic [6:0]    ec0;
  logic [2:0]    ec1, ec2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trace_monitor u_d0 (
    .clk(clk), .rst_n(rst_n), .halt_in(halt_in),
    .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_en(rd_en),
    .rd_valid(rv[0]), .rd_data(rdd[0]), .state(st[0]),
    .done(dn[0]), .cycle_count(cc[0]), .inst_count(ic[0]),
    .entry_count(ec0), .overflow(ov[0]), .proto_err(pe[0])
  );

  trace_monitor #(.DEPTH(4), .WRAP(1), .WATCHDOG(20)) u_d1 (
    .clk(clk), .rst_n(rst_n), .halt_in(halt_in),
    .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_en(rd_en),
    .rd_valid(rv[1]), .rd_data(rdd[1]), .state(st[1]),
    .done(dn[1]), .cycle_count(cc[1]), .inst_count(ic[1]),
    .entry_count(ec1), .overflow(ov[1]), .proto_err(pe[1])
  );

  trace_monitor #(.DEPTH(4), .WRAP(0), .WATCHDOG(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .halt_in(halt_in),
    .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_en(rd_en),
    .rd_valid(rv[2]), .rd_data(rdd[2]), .state(st[2]),
    .done(dn[2]), .cycle_count(cc[2]), .inst_count(ic[2]),
    .entry_count(ec2), .overflow(ov[2]), .proto_err(pe[2])
  );

  // Reference model state, one slot per instance
  int            m_st   [3];
  longint        m_cyc  [3];
  longint        m_inst [3];
  bit            m_ovf  [3];
  bit            m_perr [3];
  bit            m_rv   [3];
  logic [EW-1:0] m_rd   [3];
  logic [EW-1:0] mq     [3][$];

  function automatic logic [EW-1:0] make_entry(longint ts);
    logic [EW-1:0] e;
    logic [15:0]   md;
    md = mem_wr ? mem_wdata : (mem_rd ? mem_rdata : 16'h0);
    e  = '0;
    e[EW-1]   = reg_we;
    e[EW-2]   = mem_rd & ~mem_wr;
    e[EW-3]   = mem_wr;
    e[EW-4 -: 4]  = reg_we ? reg_idx : 4'h0;
    e[TSW+32 +: 16] = reg_we ? reg_data : 16'h0;
    e[TSW+16 +: 16] = (mem_rd | mem_wr) ? mem_addr : 16'h0;
    e[TSW +: 16]    = md;
`ifdef TRACE_TIMESTAMP_EN
    e[31:0] = ts[31:0];
`endif
    return e;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        m_st[d] = 0; m_cyc[d] = 0; m_inst[d] = 0;
        m_ovf[d] = 0; m_perr[d] = 0; m_rv[d] = 0;
        m_rd[d] = '0;
        mq[d].delete();
      end else if (m_st[d] == 0) begin
        m_rv[d] = 0;
        if (m_cyc[d] < 64'hFFFF_FFFF) m_cyc[d]++;
        if ((halt_in | reg_we | mem_wr) && m_inst[d] < 64'hFFFF_FFFF)
          m_inst[d]++;
        if (mem_rd && mem_wr) m_perr[d] = 1;
        if (reg_we | mem_rd | mem_wr) begin
          if (mq[d].size() < P_DEPTH[d]) begin
            mq[d].push_back(make_entry(m_cyc[d]));
          end else begin
            m_ovf[d] = 1;
            if (P_WRAP[d] != 0) begin
              void'(mq[d].pop_front());
              mq[d].push_back(make_entry(m_cyc[d]));
            end
          end
        end
        if (halt_in) m_st[d] = 1;
        else if (P_WD[d] != 0 && m_cyc[d] == P_WD[d]) m_st[d] = 2;
      end else begin
        m_rv[d] = 0;
        if (rd_en && mq[d].size() > 0) begin
          m_rd[d] = mq[d].pop_front();
          m_rv[d] = 1;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ecnt(int d);
    if (d == 0) return ec0;
    if (d == 1) return {4'b0, ec1};
    return {4'b0, ec2};
  endfunction

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d state", d), st[d], m_st[d]);
      chk($sformatf("d%0d done", d), dn[d], m_st[d] != 0);
      chk($sformatf("d%0d cycle", d), cc[d], m_cyc[d]);
      chk($sformatf("d%0d inst", d), ic[d], m_inst[d]);
      chk($sformatf("d%0d entries", d), ecnt(d), mq[d].size());
      chk($sformatf("d%0d overflow", d), ov[d], m_ovf[d]);
      chk($sformatf("d%0d proto", d), pe[d], m_perr[d]);
      chk($sformatf("d%0d rd_valid", d), rv[d], m_rv[d]);
      chk($sformatf("d%0d rd_data", d), rdd[d], m_rd[d]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    halt_in = 0; reg_we = 0; mem_rd = 0; mem_wr = 0; rd_en = 0;
    reg_idx = 0; reg_data = 0; mem_addr = 0;
    mem_wdata = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic wreg(logic [3:0] i, logic [15:0] v);
    idle();
    reg_we = 1; reg_idx = i; reg_data = v;
    tick();
  endtask

  task automatic do_halt();
    idle(); halt_in = 1; tick(); idle();
  endtask

  task automatic do_pop();
    idle(); rd_en = 1; tick(); idle();
  endtask

  function automatic logic [15:0] regf(logic [EW-1:0] e);
    return e[TSW+32 +: 16];
  endfunction

  typedef struct {
    logic        we;
    logic [3:0]  idx;
    logic [15:0] data;
    logic        halt;
    logic        rd;
    logic [1:0]  st;
    int          inst;
    int          cnt;
    logic        rv;
    logic [15:0] rdat;
  } vec_t;

  vec_t vecs [8];
  logic [EW-1:0] exp_e;

  initial begin
    vecs[0] = '{1, 1, 16'h0001, 0, 0, 2'b00, 1, 1, 0, 16'h0};
    vecs[1] = '{1, 2, 16'h0002, 0, 0, 2'b00, 2, 2, 0, 16'h0};
    vecs[2] = '{1, 3, 16'h0003, 0, 0, 2'b00, 3, 3, 0, 16'h0};
    vecs[3] = '{0, 0, 16'h0000, 1, 0, 2'b01, 4, 3, 0, 16'h0};
    vecs[4] = '{0, 0, 16'h0000, 0, 1, 2'b01, 4, 2, 1, 16'h1};
    vecs[5] = '{0, 0, 16'h0000, 0, 1, 2'b01, 4, 1, 1, 16'h2};
    vecs[6] = '{0, 0, 16'h0000, 0, 1, 2'b01, 4, 0, 1, 16'h3};
    vecs[7] = '{0, 0, 16'h0000, 0, 1, 2'b01, 4, 0, 0, 16'h3};

    do_reset();
    chk("reset state", st[0], 2'b00);
    chk("reset entries", ec0, 7'd0);

    // Basic capture, halt and in-order drain
    for (int i = 0; i < 8; i++) begin
      idle();
      reg_we = vecs[i].we; reg_idx = vecs[i].idx;
      reg_data = vecs[i].data; halt_in = vecs[i].halt;
      rd_en = vecs[i].rd;
      tick();
      chk($sformatf("vec%0d state", i), st[0], vecs[i].st);
      chk($sformatf("vec%0d inst", i), ic[0], vecs[i].inst);
      chk($sformatf("vec%0d entries", i), ec0, vecs[i].cnt);
      chk($sformatf("vec%0d rd_valid", i), rv[0], vecs[i].rv);
      chk($sformatf("vec%0d rd_reg", i), regf(rdd[0]), vecs[i].rdat);
    end
    idle();

    // Register write and store in one cycle share an entry
    do_reset();
    reg_we = 1; reg_idx = 5; reg_data = 16'hBEEF;
    mem_wr = 1; mem_addr = 16'h0010; mem_wdata = 16'h1234;
    tick();
    chk("shared inst", ic[0], 32'd1);
    chk("shared entries", ec0, 7'd1);
    do_halt();
    do_pop();
    exp_e = '0;
    exp_e[EW-1 -: 55] = {3'b101, 4'h5, 16'hBEEF, 16'h0010, 16'h1234};
`ifdef TRACE_TIMESTAMP_EN
    exp_e[31:0] = 32'd1;
`endif
    chk("shared entry", rdd[0], exp_e);

    // Full buffer: overwrite oldest vs drop newest
    do_reset();
    for (int i = 1; i <= 6; i++) wreg(4'(i), 16'(i));
    do_halt();
    chk("wrap entries", ec1, 3'd4);
    chk("drop entries", ec2, 3'd4);
    chk("wrap overflow", ov[1], 1'b1);
    chk("drop overflow", ov[2], 1'b1);
    for (int k = 0; k < 4; k++) begin
      do_pop();
      chk($sformatf("wrap pop%0d", k), regf(rdd[1]), 16'(3 + k));
      chk($sformatf("drop pop%0d", k), regf(rdd[2]), 16'(1 + k));
    end

    // Watchdog timeout and frozen capture afterwards
    do_reset();
    for (int i = 0; i < 19; i++) tick();
    chk("wd before", st[1], 2'b00);
    tick();
    chk("wd state", st[1], 2'b10);
    chk("wd done", dn[1], 1'b1);
    chk("wd cycle", cc[1], 32'd20);
    for (int i = 0; i < 5; i++) wreg(4'(i), 16'hAAAA);
    idle();
    chk("wd frozen entries", ec1, 3'd0);
    chk("wd frozen cycle", cc[1], 32'd20);
    chk("wd frozen inst", ic[1], 32'd0);

    // Read and write together: logged as a write, protocol error raised
    do_reset();
    mem_rd = 1; mem_wr = 1; mem_addr = 16'h0020;
    mem_rdata = 16'h1111; mem_wdata = 16'h2222;
    tick();
    chk("proto err", pe[0], 1'b1);
    do_halt();
    do_pop();
    chk("proto flags", rdd[0][EW-1 -: 3], 3'b001);
    chk("proto data", rdd[0][TSW +: 16], 16'h2222);

    // Reset in the middle of a readout
    do_reset();
    for (int i = 1; i <= 3; i++) wreg(4'(i), 16'(i));
    do_halt();
    do_pop();
    do_pop();
    rst_n = 0;
    tick();
    chk("mid rst state", st[0], 2'b00);
    chk("mid rst done", dn[0], 1'b0);
    chk("mid rst cycle", cc[0], 32'd0);
    chk("mid rst inst", ic[0], 32'd0);
    chk("mid rst entries", ec0, 7'd0);
    chk("mid rst rd_valid", rv[0], 1'b0);
    chk("mid rst rd_data", rdd[0], '0);
    rst_n = 1;

    // Capture timestamps at cycles 3 and 7
    do_reset();
    tick();
    tick();
    wreg(4'h1, 16'h0033);
    idle();
    tick();
    tick();
    tick();
    wreg(4'h2, 16'h0077);
    do_halt();
    do_pop();
    chk("ts pop0 data", regf(rdd[0]), 16'h0033);
`ifdef TRACE_TIMESTAMP_EN
    chk("ts pop0", rdd[0][31:0], 32'd3);
`endif
    do_pop();
    chk("ts pop1 data", regf(rdd[0]), 16'h0077);
`ifdef TRACE_TIMESTAMP_EN
    chk("ts pop1", rdd[0][31:0], 32'd7);
`endif

    // Randomized segments against the model
    for (int s = 0; s < 8; s++) begin
      do_reset();
      for (int c = 0; c < 90; c++) begin
        halt_in  = (c > 30) && ($urandom_range(0, 99) < 8);
        reg_we   = $urandom_range(0, 99) < 40;
        mem_rd   = $urandom_range(0, 99) < 25;
        mem_wr   = $urandom_range(0, 99) < 25;
        rd_en    = $urandom_range(0, 99) < 50;
        reg_idx  = 4'($urandom);
        reg_data = 16'($urandom);
        mem_addr = 16'($urandom);
        mem_wdata = 16'($urandom);
        mem_rdata = 16'($urandom);
        rst_n    = $urandom_range(0, 149) != 0;
        tick();
      end
      idle();
      rst_n = 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
